gate_bist_ctrl: RTL and testbench
=================================

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 11: width of the pattern driven into the gate model (inputs N1..N11).
REQ-002 SHALL have parameter RSP_W, default 10: width of the response captured from the gate model outputs.
REQ-003 SHALL have parameter SETTLE_CYC, default 2, legal range 1..15: wait cycles between applying a pattern and capturing its response.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  run request; sampled only in IDLE.
REQ-007 abort  in  1  terminates a run; effective in any state except IDLE.
REQ-008 seed  in  PAT_W  LFSR seed, loaded when start is accepted.
REQ-009 num_pat  in  16  number of patterns per run.
REQ-010 golden  in  RSP_W  expected signature, compared in DONE.
REQ-011 dut_out  in  RSP_W  gate-model response.
REQ-012 dut_in  out  PAT_W  registered pattern to the gate model; dut_in[0] drives N1.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse, high only in DONE.
REQ-015 pass  out  1  registered compare result.
REQ-016 signature  out  RSP_W  current MISR contents.
REQ-017 pat_cnt  out  16  number of patterns captured in the current or last run.

Function
REQ-018 FSM states SHALL be IDLE, APPLY, SETTLE, CAPTURE, DONE.
REQ-019 In IDLE with start=1, the block SHALL do all of the following:
- load the LFSR with seed, or with 1 if seed==0;
- clear the MISR and pat_cnt to 0;
- clear pass;
- go to DONE if num_pat==0, otherwise go to APPLY.
REQ-020 In IDLE with start=0, the block SHALL hold all registers.
REQ-021 APPLY SHALL register dut_in <= LFSR, load the settle counter with SETTLE_CYC, and go to SETTLE.
REQ-022 SETTLE SHALL decrement the settle counter each cycle and go to CAPTURE on the cycle the counter reads 1, so SETTLE lasts exactly SETTLE_CYC cycles.
REQ-023 CAPTURE SHALL update the MISR, increment pat_cnt, and advance the LFSR; it SHALL go to DONE if pat_cnt+1==num_pat, otherwise to APPLY.
REQ-024 The LFSR SHALL be Fibonacci x^11+x^9+1: next = {lfsr[9:0], lfsr[10]^lfsr[8]}.
REQ-025 The MISR SHALL be Galois x^10+x^3+1: next = ({misr[8:0],1'b0} ^ (misr[9] ? 10'h009 : 0)) ^ dut_out.
REQ-026 DONE SHALL assert done, register pass <= (signature==golden), and return to IDLE on the next edge.
REQ-027 Each pattern SHALL take exactly SETTLE_CYC+2 cycles (APPLY + SETTLE + CAPTURE).
REQ-028 Counting the start-accept edge as edge 0, done SHALL go high after edge num_pat*(SETTLE_CYC+2).
REQ-029 abort=1 in a non-IDLE state SHALL force IDLE at the next edge with no done pulse and pass=0; signature, pat_cnt and dut_in keep their partial values.
REQ-030 abort SHALL take priority over every other transition, including CAPTURE→DONE.
REQ-031 start while busy SHALL be ignored.
REQ-032 start and abort both high in IDLE SHALL be treated as a start.
REQ-033 After a run, dut_in, signature and pat_cnt SHALL hold their values until the next accepted start.
REQ-034 num_pat=16'hFFFF SHALL run 65535 patterns; pat_cnt SHALL NOT wrap within a run.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE and the following values: dut_in=0, busy=0, done=0, pass=0, signature=0, pat_cnt=0, LFSR=1, settle counter=0.
REQ-036 Asserting rst_n mid-run SHALL discard the run with no done pulse; the first start after release SHALL begin a fresh run.

Verification
REQ-037 seed=0x001, num_pat=2, dut_out=0, golden=0:
- dut_in = 0x001, then 0x002;
- done after edge 8; signature=0, pass=1, pat_cnt=2.
REQ-038 seed=0x001, num_pat=2, dut_out held at 0x001, golden=0x003 -> signature=0x003, pass=1; repeating with golden=0x002 -> pass=0.
REQ-039 seed=0, num_pat=3 -> first dut_in=0x001; done after edge 12.
REQ-039a num_pat=0 -> done after edge 0, signature=0, pat_cnt=0.
REQ-040 abort during the second SETTLE of a 4-pattern run:
- idle next cycle, no done pulse, pass=0;
- pat_cnt=1;
- a start pulse during the run is ignored.
REQ-041 rst_n low during CAPTURE -> all outputs at reset values immediately; a new start afterwards completes normally.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// LFSR-pattern BIST controller for a combinational gate model: apply, settle, capture into a MISR, compare.
// One pattern every SETTLE_CYC+2 cycles; abort returns to IDLE on the next edge, start is ignored while busy.
module gate_bist_ctrl #(
    parameter int PAT_W      = 11,
    parameter int RSP_W      = 10,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] seed,
    input  logic [15:0]      num_pat,
    input  logic [RSP_W-1:0] golden,
    input  logic [RSP_W-1:0] dut_out,
    output logic [PAT_W-1:0] dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [RSP_W-1:0] signature,
    output logic [15:0]      pat_cnt
);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CAPTURE, DONE} state_t;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYC);
    localparam logic [RSP_W-1:0] MISR_POLY = RSP_W'(9);

    state_t           state, state_nxt;
    logic [PAT_W-1:0] lfsr, lfsr_nxt;
    logic [RSP_W-1:0] misr_nxt;
    logic [15:0]      pat_cnt_nxt;
    logic [3:0]       settle_cnt;

    assign lfsr_nxt    = {lfsr[PAT_W-2:0], lfsr[PAT_W-1] ^ lfsr[PAT_W-3]};
    assign misr_nxt    = {signature[RSP_W-2:0], 1'b0}
                       ^ (signature[RSP_W-1] ? MISR_POLY : '0) ^ dut_out;
    assign pat_cnt_nxt = pat_cnt + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_pat == 16'd0) ? DONE : APPLY;
            APPLY:   state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == 4'd1) state_nxt = CAPTURE;
            CAPTURE: state_nxt = (pat_cnt_nxt == num_pat) ? DONE : APPLY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort wins over every transition, including CAPTURE -> DONE
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= PAT_W'(1);
            dut_in     <= '0;
            signature  <= '0;
            pat_cnt    <= '0;
            settle_cnt <= '0;
            pass       <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                lfsr      <= (seed == '0) ? PAT_W'(1) : seed;
                signature <= '0;
                pat_cnt   <= '0;
                pass      <= 1'b0;
            end
        end else if (abort) begin
            // partial results stay visible; only the verdict is cleared
            pass <= 1'b0;
        end else begin
            case (state)
                APPLY: begin
                    dut_in     <= lfsr;
                    settle_cnt <= SETTLE_LD;
                end
                SETTLE:  settle_cnt <= settle_cnt - 4'd1;
                CAPTURE: begin
                    signature <= misr_nxt;
                    pat_cnt   <= pat_cnt_nxt;
                    lfsr      <= lfsr_nxt;
                end
                DONE:    pass <= (signature == golden);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: table of full runs plus abort, start/abort collision and mid-run reset sequences.
module tb_gate_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] seed = '0;
    logic [15:0] num_pat = '0;
    logic [9:0]  golden = '0;
    logic [9:0]  dut_out = '0;
    logic [10:0] dut_in;
    logic        busy, done, pass;
    logic [9:0]  signature;
    logic [15:0] pat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    gate_bist_ctrl #(.PAT_W(11), .RSP_W(10), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
        .num_pat(num_pat), .golden(golden), .dut_out(dut_out), .dut_in(dut_in),
        .busy(busy), .done(done), .pass(pass), .signature(signature), .pat_cnt(pat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] seed;
        logic [15:0] num_pat;
        logic [9:0]  dout;
        logic [9:0]  golden;
        logic [9:0]  exp_sig;
        logic        exp_pass;
        logic [15:0] exp_cnt;
        logic [10:0] exp_first;
        logic [10:0] exp_last;
        int          exp_edge;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start a run at the next edge (edge 0) and follow it until one edge past DONE.
    task automatic run_vec(input vec_t v, input int idx);
        int done_edge;
        logic [10:0] first_din;
        done_edge = -1;
        first_din = '0;
        seed = v.seed; num_pat = v.num_pat; dut_out = v.dout; golden = v.golden;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (done) done_edge = 0;
        for (int k = 1; k <= 200 && done_edge < 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) first_din = dut_in;
            if (done) done_edge = k;
        end
        check($sformatf("v%0d_done_edge", idx), 32'(done_edge), 32'(v.exp_edge));
        if (v.num_pat != 16'd0)
            check($sformatf("v%0d_first_din", idx), 32'(first_din), 32'(v.exp_first));
        check($sformatf("v%0d_sig", idx), 32'(signature), 32'(v.exp_sig));
        check($sformatf("v%0d_cnt", idx), 32'(pat_cnt), 32'(v.exp_cnt));
        @(posedge clk); #1;
        check($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
        check($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d_pass", idx), 32'(pass), 32'(v.exp_pass));
        check($sformatf("v%0d_last_din", idx), 32'(dut_in), 32'(v.exp_last));
    endtask

    initial begin
        logic saw_done;
        //           seed     n      dout    golden  sig     pass  cnt    first    last     edge
        vecs[0] = '{11'h001, 16'd2, 10'h000, 10'h000, 10'h000, 1'b1, 16'd2, 11'h001, 11'h002, 8};
        vecs[1] = '{11'h001, 16'd2, 10'h001, 10'h003, 10'h003, 1'b1, 16'd2, 11'h001, 11'h002, 8};
        vecs[2] = '{11'h001, 16'd2, 10'h001, 10'h002, 10'h003, 1'b0, 16'd2, 11'h001, 11'h002, 8};
        vecs[3] = '{11'h000, 16'd3, 10'h000, 10'h000, 10'h000, 1'b1, 16'd3, 11'h001, 11'h004, 12};
        vecs[4] = '{11'h005, 16'd0, 10'h000, 10'h000, 10'h000, 1'b1, 16'd0, 11'h000, 11'h004, 0};
        vecs[5] = '{11'h400, 16'd3, 10'h3FF, 10'h3EF, 10'h3EF, 1'b1, 16'd3, 11'h400, 11'h002, 12};
        vecs[6] = '{11'h123, 16'd1, 10'h155, 10'h000, 10'h155, 1'b0, 16'd1, 11'h123, 11'h123, 4};

        #12;
        check("rst_din",  32'(dut_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_sig",  32'(signature), 32'd0);
        check("rst_cnt",  32'(pat_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // abort in the second SETTLE of a 4-pattern run; stray start mid-run
        seed = 11'h001; num_pat = 16'd4; dut_out = '0; golden = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        saw_done = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            saw_done |= done;
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            if (k == 4) check("abort_mid_cnt", 32'(pat_cnt), 32'd1);
        end
        check("abort_mid_din", 32'(dut_in), 32'h002);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        saw_done |= done;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_cnt",  32'(pat_cnt), 32'd1);
        check("abort_din",  32'(dut_in), 32'h002);
        @(posedge clk); #1;
        saw_done |= done;
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // start and abort together in IDLE: start wins
        seed = 11'h001; num_pat = 16'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("start_abort_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("start_abort_pass", 32'(pass), 32'd1);

        // reset while in CAPTURE of the first pattern
        seed = 11'h001; num_pat = 16'd2; dut_out = 10'h001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_din",  32'(dut_in), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_pass", 32'(pass), 32'd0);
        check("mrst_sig",  32'(signature), 32'd0);
        check("mrst_cnt",  32'(pat_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[1], 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
